// File: rtl/mmc5_snd_pkg.sv
// Shared MMC5 sound register map, CTRL bit layout and PRG read-window decode.
package mmc5_snd_pkg;

  localparam logic [14:0] REG_PCM_CTRL   = 15'h5010;
  localparam logic [14:0] REG_PCM_DATA   = 15'h5011;
  localparam logic [14:0] REG_SND_STATUS = 15'h5015;

  localparam int unsigned MODE_BIT  = 0;
  localparam int unsigned IRQEN_BIT = 7;
  localparam int unsigned FLAG_BIT  = 7;

  // With A15 already qualified by rom_sel, $8000-$BFFF is simply A14 = 0.
  localparam int unsigned PRG_WIN_BIT = 14;
  localparam logic        PRG_WIN_VAL = 1'b0;

  function automatic logic prg_pcm_window(input logic [14:0] addr);
    return addr[PRG_WIN_BIT] == PRG_WIN_VAL;
  endfunction

endpackage

// File: rtl/mmc5_pcm_ctl_if.sv
// CPU-side bus bundle for the MMC5 PCM front end; the CPU/bus model is master.
interface mmc5_pcm_ctl_if;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_dat;
  logic        cpu_rw;
  logic        cpu_ce;
  logic        rom_sel;
  logic [7:0]  dat_out;
  logic        dat_oe;

  modport master (
    output cpu_addr, cpu_dat, cpu_rw, cpu_ce, rom_sel,
    input  dat_out, dat_oe
  );

  modport slave (
    input  cpu_addr, cpu_dat, cpu_rw, cpu_ce, rom_sel,
    output dat_out, dat_oe
  );
endinterface

// File: rtl/mmc5_pcm_slew.sv
// Slew limiter: moves pcm toward the target sample by at most SLEW_STEP per falling m2.
module mmc5_pcm_slew #(
  parameter int unsigned SLEW_STEP = 4
) (
  input  logic       m2,
  input  logic       rst_n,
  input  logic [7:0] pcm_lat_i,
  output logic [7:0] pcm_o
);

  localparam logic [7:0] STEP = 8'(SLEW_STEP);

  logic [7:0] pcm_q, pcm_d;

  // Distance is taken before stepping, so a large step can never overshoot or wrap.
  always_comb begin
    pcm_d = pcm_q;
    if (pcm_lat_i > pcm_q) begin
      if ((pcm_lat_i - pcm_q) <= STEP) pcm_d = pcm_lat_i;
      else                             pcm_d = pcm_q + STEP;
    end else if (pcm_lat_i < pcm_q) begin
      if ((pcm_q - pcm_lat_i) <= STEP) pcm_d = pcm_lat_i;
      else                             pcm_d = pcm_q - STEP;
    end
  end

  always_ff @(negedge m2 or negedge rst_n) begin
    if (!rst_n) pcm_q <= '0;
    else        pcm_q <= pcm_d;
  end

  assign pcm_o = pcm_q;

endmodule

// File: rtl/mmc5_pcm_ctl.sv
// MMC5 PCM channel front end: $5010/$5011 decode, write/read sample modes, zero-fetch IRQ.
// Optional output slew limiting is enabled with `define MMC5_PCM_SLEW_EN.
module mmc5_pcm_ctl
  import mmc5_snd_pkg::*;
#(
  parameter logic [14:0] ADDR_CTRL = REG_PCM_CTRL,
  parameter logic [14:0] ADDR_DATA = REG_PCM_DATA,
  parameter int unsigned SLEW_STEP = 4
) (
  input  logic                 m2,
  input  logic                 rst_n,
  mmc5_pcm_ctl_if.slave        bus,
  output logic [7:0]           pcm,
  output logic                 irq_n
);

  logic       mode_q,     mode_d;
  logic       irq_en_q,   irq_en_d;
  logic       irq_flag_q, irq_flag_d;
  logic [7:0] pcm_lat_q,  pcm_lat_d;

  logic ctrl_hit, data_hit;
  logic ctrl_wr, ctrl_rd, data_wr, prg_rd;
  logic dat_zero;

  always_comb begin
    ctrl_hit = bus.cpu_ce && (bus.cpu_addr == ADDR_CTRL);
    data_hit = bus.cpu_ce && (bus.cpu_addr == ADDR_DATA);
    ctrl_wr  = ctrl_hit && !bus.cpu_rw;
    ctrl_rd  = ctrl_hit &&  bus.cpu_rw;
    data_wr  = data_hit && !bus.cpu_rw;
    prg_rd   = bus.rom_sel && bus.cpu_rw && prg_pcm_window(bus.cpu_addr);
    dat_zero = (bus.cpu_dat == 8'h00);
  end

  always_comb begin
    mode_d     = mode_q;
    irq_en_d   = irq_en_q;
    irq_flag_d = irq_flag_q;
    pcm_lat_d  = pcm_lat_q;

    if (ctrl_wr) begin
      mode_d   = bus.cpu_dat[MODE_BIT];
      irq_en_d = bus.cpu_dat[IRQEN_BIT];
    end

    if (ctrl_rd) irq_flag_d = 1'b0;

    if (data_wr && !mode_q && !dat_zero) pcm_lat_d = bus.cpu_dat;

    // A zero byte fetched in read mode is the end-of-sample marker: hold level, flag IRQ.
    if (prg_rd && mode_q) begin
      if (dat_zero) irq_flag_d = 1'b1;
      else          pcm_lat_d  = bus.cpu_dat;
    end
  end

  always_ff @(negedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_flag_q <= 1'b0;
      pcm_lat_q  <= '0;
    end else begin
      mode_q     <= mode_d;
      irq_en_q   <= irq_en_d;
      irq_flag_q <= irq_flag_d;
      pcm_lat_q  <= pcm_lat_d;
    end
  end

  always_comb begin
    bus.dat_oe  = ctrl_rd;
    bus.dat_out = '0;
    if (ctrl_rd) bus.dat_out[FLAG_BIT] = irq_flag_q;
  end

  assign irq_n = !(irq_flag_q && irq_en_q);

`ifdef MMC5_PCM_SLEW_EN
  // Fed with the next latch value so the first step lands on the capturing edge.
  mmc5_pcm_slew #(
    .SLEW_STEP (SLEW_STEP)
  ) u_slew (
    .m2        (m2),
    .rst_n     (rst_n),
    .pcm_lat_i (pcm_lat_d),
    .pcm_o     (pcm)
  );
`else
  assign pcm = pcm_lat_q;
`endif

endmodule

// File: tb/tb_mmc5_pcm_ctl.sv
// Self-checking bench for mmc5_pcm_ctl: directed scenarios plus randomized bus traffic vs. a reference model.
module tb_mmc5_pcm_ctl;

  logic       m2;
  logic       rst_n;
  logic [7:0] pcm;
  logic       irq_n;

  mmc5_pcm_ctl_if bus ();

  mmc5_pcm_ctl #(
    .ADDR_CTRL (15'h5010),
    .ADDR_DATA (15'h5011),
    .SLEW_STEP (4)
  ) dut (
    .m2    (m2),
    .rst_n (rst_n),
    .bus   (bus),
    .pcm   (pcm),
    .irq_n (irq_n)
  );

  initial m2 = 1'b0;
  always #5 m2 = ~m2;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit       m_mode, m_irqen, m_flag;
  bit [7:0] m_lat, m_pcm;

  logic       oe_s, exp_oe;
  logic [7:0] out_s, exp_out;

  function automatic void model_reset();
    m_mode = 0; m_irqen = 0; m_flag = 0; m_lat = 0; m_pcm = 0;
  endfunction

  function automatic void model_pcm_step();
`ifdef MMC5_PCM_SLEW_EN
    int diff;
    diff = int'(m_lat) - int'(m_pcm);
    if (diff >= -4 && diff <= 4) m_pcm = m_lat;
    else if (diff > 0)           m_pcm = 8'(int'(m_pcm) + 4);
    else                         m_pcm = 8'(int'(m_pcm) - 4);
`else
    m_pcm = m_lat;
`endif
  endfunction

  // One CPU cycle, entered just after a falling m2; returns just after the next one.
  task automatic access(input logic [15:0] a, input logic [7:0] d, input logic rw,
                        output logic oe_o, output logic [7:0] out_o,
                        output logic eoe, output logic [7:0] eout);
    bit is_reg, is_ctrl, is_data, is_win;
    bus.cpu_addr = a[14:0];
    bus.cpu_dat  = d;
    bus.cpu_rw   = rw;
    bus.rom_sel  = a[15];
    bus.cpu_ce   = (a[15:14] == 2'b01);
    @(posedge m2); #1;
    oe_o  = bus.dat_oe;
    out_o = bus.dat_out;
    @(negedge m2); #1;
    is_reg  = (a >= 16'h4000 && a <= 16'h7FFF);
    is_ctrl = is_reg && a == 16'h5010;
    is_data = is_reg && a == 16'h5011;
    is_win  = (a >= 16'h8000 && a <= 16'hBFFF);
    eoe  = is_ctrl && rw;
    eout = eoe ? (m_flag ? 8'h80 : 8'h00) : 8'h00;
    if (is_ctrl && !rw) begin m_mode = d[0]; m_irqen = d[7]; end
    if (is_ctrl && rw) m_flag = 0;
    if (is_data && !rw && !m_mode && d != 0) m_lat = d;
    if (is_win && rw && m_mode) begin
      if (d != 0) m_lat = d;
      else        m_flag = 1;
    end
    model_pcm_step();
  endtask

  task automatic idle();
    access(16'h0000, 8'h00, 1'b1, oe_s, out_s, exp_oe, exp_out);
  endtask

  task automatic settle();
`ifdef MMC5_PCM_SLEW_EN
    repeat (70) idle();
`endif
  endtask

  task automatic test_reset();
    access(16'h5011, 8'h33, 1'b0, oe_s, out_s, exp_oe, exp_out);
    access(16'h5010, 8'h81, 1'b0, oe_s, out_s, exp_oe, exp_out);
    access(16'h9000, 8'h00, 1'b1, oe_s, out_s, exp_oe, exp_out);
    settle();
    checks++;
    if (irq_n !== 1'b0) begin errors++; $display("FAIL pre_reset_irq got %b exp %b", irq_n, 1'b0); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pcm !== 8'h00) begin errors++; $display("FAIL reset_pcm got %h exp %h", pcm, 8'h00); end
    checks++;
    if (irq_n !== 1'b1) begin errors++; $display("FAIL reset_irq_n got %b exp %b", irq_n, 1'b1); end
    checks++;
    if (bus.dat_oe !== 1'b0) begin errors++; $display("FAIL reset_dat_oe got %b exp %b", bus.dat_oe, 1'b0); end
    rst_n = 1'b1;
    @(negedge m2); #1;
    model_reset();
    access(16'h5010, 8'h00, 1'b1, oe_s, out_s, exp_oe, exp_out);
    checks++;
    if (oe_s !== 1'b1 || out_s !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl_read got oe=%b dat=%h exp oe=1 dat=00", oe_s, out_s);
    end
  endtask

  task automatic test_write_mode();
    access(16'h5011, 8'h80, 1'b0, oe_s, out_s, exp_oe, exp_out);
    settle();
    checks++;
    if (pcm !== 8'h80) begin errors++; $display("FAIL wmode_pcm got %h exp %h", pcm, 8'h80); end
    access(16'h5011, 8'h00, 1'b0, oe_s, out_s, exp_oe, exp_out);
    settle();
    checks++;
    if (pcm !== 8'h80) begin errors++; $display("FAIL wmode_zero_ignored got %h exp %h", pcm, 8'h80); end
    access(16'h5011, 8'h00, 1'b1, oe_s, out_s, exp_oe, exp_out);
    checks++;
    if (oe_s !== 1'b0) begin errors++; $display("FAIL data_reg_read_oe got %b exp %b", oe_s, 1'b0); end
    access(16'h8123, 8'h42, 1'b1, oe_s, out_s, exp_oe, exp_out);
    settle();
    checks++;
    if (pcm !== 8'h80) begin errors++; $display("FAIL wmode_prg_read got %h exp %h", pcm, 8'h80); end
  endtask

  task automatic test_read_mode();
    access(16'h5010, 8'h81, 1'b0, oe_s, out_s, exp_oe, exp_out);
    access(16'h8123, 8'h42, 1'b1, oe_s, out_s, exp_oe, exp_out);
    settle();
    checks++;
    if (pcm !== 8'h42) begin errors++; $display("FAIL rmode_capture got %h exp %h", pcm, 8'h42); end
    access(16'hC000, 8'h11, 1'b1, oe_s, out_s, exp_oe, exp_out);
    access(16'h8123, 8'h55, 1'b0, oe_s, out_s, exp_oe, exp_out);
    access(16'h5011, 8'h77, 1'b0, oe_s, out_s, exp_oe, exp_out);
    settle();
    checks++;
    if (pcm !== 8'h42) begin errors++; $display("FAIL rmode_ignored got %h exp %h", pcm, 8'h42); end
  endtask

  task automatic test_zero_irq();
    access(16'h9000, 8'h00, 1'b1, oe_s, out_s, exp_oe, exp_out);
    checks++;
    if (irq_n !== 1'b0) begin errors++; $display("FAIL zero_fetch_irq got %b exp %b", irq_n, 1'b0); end
    checks++;
    if (pcm !== 8'h42) begin errors++; $display("FAIL zero_fetch_pcm got %h exp %h", pcm, 8'h42); end
    access(16'h5010, 8'h00, 1'b1, oe_s, out_s, exp_oe, exp_out);
    checks++;
    if (oe_s !== 1'b1 || out_s !== 8'h80) begin
      errors++; $display("FAIL status_read got oe=%b dat=%h exp oe=1 dat=80", oe_s, out_s);
    end
    checks++;
    if (irq_n !== 1'b1) begin errors++; $display("FAIL status_clear_irq got %b exp %b", irq_n, 1'b1); end
    access(16'h5010, 8'h00, 1'b1, oe_s, out_s, exp_oe, exp_out);
    checks++;
    if (out_s !== 8'h00) begin errors++; $display("FAIL status_reread got %h exp %h", out_s, 8'h00); end
  endtask

  task automatic test_irq_mask();
    access(16'hA000, 8'h00, 1'b1, oe_s, out_s, exp_oe, exp_out);
    access(16'h5010, 8'h01, 1'b0, oe_s, out_s, exp_oe, exp_out);
    checks++;
    if (irq_n !== 1'b1) begin errors++; $display("FAIL irq_masked got %b exp %b", irq_n, 1'b1); end
    access(16'h5010, 8'h81, 1'b0, oe_s, out_s, exp_oe, exp_out);
    checks++;
    if (irq_n !== 1'b0) begin errors++; $display("FAIL irq_unmasked got %b exp %b", irq_n, 1'b0); end
    access(16'h5010, 8'h00, 1'b0, oe_s, out_s, exp_oe, exp_out);
    settle();
    checks++;
    if (pcm !== 8'h42) begin errors++; $display("FAIL mode_change_pcm got %h exp %h", pcm, 8'h42); end
    access(16'h5010, 8'h00, 1'b1, oe_s, out_s, exp_oe, exp_out);
  endtask

  task automatic test_latency_slew();
    rst_n = 1'b0; #1; rst_n = 1'b1;
    @(negedge m2); #1;
    model_reset();
    access(16'h5011, 8'h0A, 1'b0, oe_s, out_s, exp_oe, exp_out);
`ifdef MMC5_PCM_SLEW_EN
    checks++;
    if (pcm !== 8'h04) begin errors++; $display("FAIL slew_step1 got %h exp %h", pcm, 8'h04); end
    idle();
    checks++;
    if (pcm !== 8'h08) begin errors++; $display("FAIL slew_step2 got %h exp %h", pcm, 8'h08); end
    idle();
    checks++;
    if (pcm !== 8'h0A) begin errors++; $display("FAIL slew_step3 got %h exp %h", pcm, 8'h0A); end
    access(16'h5011, 8'h01, 1'b0, oe_s, out_s, exp_oe, exp_out);
    idle();
    idle();
    checks++;
    if (pcm !== 8'h01) begin errors++; $display("FAIL slew_down got %h exp %h", pcm, 8'h01); end
`else
    checks++;
    if (pcm !== 8'h0A) begin errors++; $display("FAIL capture_latency got %h exp %h", pcm, 8'h0A); end
`endif
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [7:0]  d;
    logic        rw;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: a = 16'h5010;
        1: a = 16'h5011;
        2: a = 16'h8000 + 16'($urandom_range(0, 16'h3FFF));
        3: a = 16'hC000 + 16'($urandom_range(0, 16'h3FFF));
        4: a = 16'h4000 + 16'($urandom_range(0, 16'h3FFF));
        default: a = 16'($urandom_range(0, 16'h3FFF));
      endcase
      d  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      rw = 1'($urandom);
      access(a, d, rw, oe_s, out_s, exp_oe, exp_out);
      checks++;
      if (oe_s !== exp_oe || out_s !== exp_out) begin
        errors++;
        $display("FAIL rand_bus[%0d] a=%h got oe=%b dat=%h exp oe=%b dat=%h", i, a, oe_s, out_s, exp_oe, exp_out);
      end
      checks++;
      if (pcm !== m_pcm || irq_n !== !(m_flag && m_irqen)) begin
        errors++;
        $display("FAIL rand_state[%0d] got pcm=%h irq_n=%b exp pcm=%h irq_n=%b", i, pcm, irq_n, m_pcm, !(m_flag && m_irqen));
      end
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_dat  = '0;
    bus.cpu_rw   = 1'b1;
    bus.cpu_ce   = 1'b0;
    bus.rom_sel  = 1'b0;
    model_reset();
    #12 rst_n = 1'b1;
    @(negedge m2); #1;
    test_reset();
    test_write_mode();
    test_read_mode();
    test_zero_irq();
    test_irq_mask();
    test_latency_slew();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mmc5_pcm_ctl.md
Name: mmc5_pcm_ctl

Overview:
MMC5 PCM channel front end. It decodes the $5010/$5011 register pair and implements both MMC5 PCM modes:
- Write mode: samples come from CPU writes to $5011.
- Read mode: samples are snooped from CPU reads of PRG space $8000-$BFFF.

It drives the 8-bit PCM level consumed by the downstream sound/PWM block. It also raises the PCM IRQ when a zero sample is fetched in read mode.

Parameters:
ADDR_CTRL, 15'h5010, control/status register address (cpu_addr[14:0] compare)
ADDR_DATA, 15'h5011, PCM data register address
SLEW_STEP, 4, max PCM output change per m2 cycle; used only with MMC5_PCM_SLEW_EN

Ports:
m2  input  1  CPU M2; all flops update on its falling edge
rst_n  input  1  asynchronous active-low reset
cpu_addr  input  15  CPU A14..A0
cpu_dat  input  8  CPU data bus (CPU write data or PRG ROM read data)
cpu_rw  input  1  1 = read, 0 = write
cpu_ce  input  1  active-high $4000-$7FFF register-space select
rom_sel  input  1  active-high, CPU A15 = 1 (PRG space)
dat_out  output  8  register read data
dat_oe  output  1  dat_out valid; bus driver enable
pcm  output  8  PCM level to the sound/PWM stage
irq_n  output  1  active-low PCM IRQ request

Behaviour:
- Reset (rst_n low, asynchronous): mode=0 (write mode), irq_en=0, irq_flag=0, pcm=0. Outputs after reset: irq_n=1, dat_oe=0.
- Register state: mode (1 bit), irq_en (1 bit), irq_flag (1 bit), pcm_lat (8 bits). All update on falling m2 only.
- Write to ADDR_CTRL (cpu_ce & !cpu_rw & addr match):
  - mode <= cpu_dat[0]; irq_en <= cpu_dat[7].
  - irq_flag is not changed.
- Read of ADDR_CTRL (cpu_ce & cpu_rw & addr match):
  - dat_oe=1 and dat_out={irq_flag,7'b0}, combinational, for the whole cycle.
  - irq_flag <= 0 at the falling m2 ending that cycle. The read value reflects the flag before clearing.
- dat_oe=0 for every other access, including reads of ADDR_DATA (write-only).
- Write to ADDR_DATA:
  - Write mode: pcm_lat <= cpu_dat if cpu_dat != 0; $00 is ignored.
  - Read mode: the write is ignored.
- Read-mode capture: on rom_sel & !cpu_addr[14] & cpu_rw (reads of $8000-$BFFF) while mode=1:
  - cpu_dat != 0: pcm_lat <= cpu_dat.
  - cpu_dat == 0: pcm_lat is held and irq_flag <= 1.
- In write mode, reads of $8000-$BFFF have no effect. Reads of $C000-$FFFF and all writes to PRG space are never captured.
- irq_n = !(irq_flag & irq_en), combinational from flops.
  - Clearing irq_en masks irq_n but keeps irq_flag.
  - Setting irq_en with irq_flag already set asserts irq_n on the next falling m2.
- Mode change leaves pcm_lat unchanged.
- Simultaneous zero-capture and ADDR_CTRL read are impossible (one bus access per cycle).
- Latency: pcm reflects a new sample immediately after the falling m2 that captured it (without slew).
- No counters wrap. rst_n asserted mid-access aborts the access; the state is reset.

Optional Feature:
MMC5_PCM_SLEW_EN:
- Defined: pcm is a separate register that steps toward pcm_lat by at most SLEW_STEP per falling m2. If |pcm_lat-pcm| <= SLEW_STEP, pcm <= pcm_lat.
  - Unsigned 8-bit compare; no overshoot or wrap past 0/255.
  - Reset sets pcm=0.
- Undefined: pcm = pcm_lat directly; no slew register exists.

Decomposition:
- Package mmc5_snd_pkg holds:
  - register address constants ($5010, $5011, $5015);
  - CTRL bit positions (MODE_BIT=0, IRQEN_BIT=7, FLAG_BIT=7);
  - PRG read window decode constants.
- Natural sub-module: mmc5_pcm_slew (pcm_lat in, pcm out, SLEW_STEP parameter), instantiated only under MMC5_PCM_SLEW_EN.

Test Plan:
- Reset: pulse rst_n low mid-cycle -> pcm=0, irq_n=1, dat_oe=0 asynchronously. Read $5010 -> dat_out=8'h00.
- Write mode: write $5011=8'h80 -> pcm=8'h80. Then write $5011=8'h00 -> pcm stays 8'h80.
- Read mode: write $5010=8'h81, then CPU read $8123 with data 8'h42 -> pcm=8'h42. Read $C000 with data 8'h11 -> pcm stays 8'h42.
- Zero fetch IRQ:
  - In read mode with irq_en=1, read $9000 data 8'h00 -> pcm unchanged, irq_n=0 after that falling m2.
  - Read $5010 -> dat_out=8'h80, dat_oe=1, then irq_n=1 and the next read returns 8'h00.
- IRQ masking: with flag set and write $5010=8'h01 -> irq_n=1. Write $5010=8'h81 -> irq_n=0 again.
- Slew (macro defined, SLEW_STEP=4): from pcm=0, write $5011=8'h0A -> pcm sequence 4, 8, 10 over three falling m2 edges.
